field_extract_pipe: RTL



---
 rtl/field_extract_pipe.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/field_extract_pipe.sv
// Multi-field header extractor: latches one header and FIELD_NUM descriptors, extracts LANE_NUM
// fields per cycle and presents the full set on a valid/ready port. Optional stats: FIELD_EXTRACT_STAT_EN.
module field_extract_pipe #(
    parameter int CANDI_NUM     = 128,
    parameter int OFFSET_WIDTH  = 7,
    parameter int EXTRACT_WIDTH = 8,
    parameter int FIELD_NUM     = 8,
    parameter int LANE_NUM      = 2
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_head_valid,
    output logic                                 o_head_ready,
    input  logic [CANDI_NUM*EXTRACT_WIDTH-1:0]   i_head_data,
    input  logic [FIELD_NUM*(OFFSET_WIDTH+1)-1:0] i_offset,
    output logic                                 o_field_valid,
    input  logic                                 i_field_ready,
    output logic [FIELD_NUM*EXTRACT_WIDTH-1:0]   o_field_data,
    output logic [FIELD_NUM-1:0]                 o_field_hit,
    output logic [FIELD_NUM-1:0]                 o_field_err
`ifdef FIELD_EXTRACT_STAT_EN
    ,
    output logic [31:0]                          o_stat_hdr_cnt,
    output logic [31:0]                          o_stat_err_cnt
`endif
);

    localparam int PASS_NUM = (FIELD_NUM + LANE_NUM - 1) / LANE_NUM;
    localparam int CNT_W    = (PASS_NUM > 1) ? $clog2(PASS_NUM) : 1;
    localparam int HEAD_IW  = (CANDI_NUM > 1) ? $clog2(CANDI_NUM) : 1;
    localparam int FIELD_IW = (FIELD_NUM > 1) ? $clog2(FIELD_NUM) : 1;
    localparam int DESC_W   = OFFSET_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PASS_NUM - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXTRACT,
        OUTPUT
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q;
    logic                      accept;
    logic                      deliver;

    logic [EXTRACT_WIDTH-1:0]  head_q [CANDI_NUM];
    logic [DESC_W-1:0]         desc_q [FIELD_NUM];
    logic [EXTRACT_WIDTH-1:0]  data_q [FIELD_NUM];
    logic [FIELD_NUM-1:0]      hit_q;
    logic [FIELD_NUM-1:0]      err_q;

    logic [LANE_NUM-1:0]       lane_live;
    logic [LANE_NUM-1:0]       lane_in;
    logic [LANE_NUM-1:0]       lane_hit;
    logic [LANE_NUM-1:0]       lane_err;
    logic [FIELD_IW-1:0]       lane_field [LANE_NUM];
    logic [DESC_W-1:0]         lane_desc  [LANE_NUM];
    logic [HEAD_IW-1:0]        lane_unit  [LANE_NUM];
    logic [EXTRACT_WIDTH-1:0]  lane_data  [LANE_NUM];

    assign accept        = i_head_valid & o_head_ready;
    assign deliver       = (state_q == OUTPUT) & i_field_ready;
    assign o_field_valid = (state_q == OUTPUT);

    // NOTE: every variable written in always_comb gets a value on every path; a missed
    // default would infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXTRACT;
            EXTRACT: if (cnt_q == CNT_LAST) state_d = OUTPUT;
            OUTPUT:  if (i_field_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready is registered so it stays low while reset is asserted and rises one cycle after release.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            o_head_ready <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            o_head_ready <= (state_d == IDLE);
            if (accept || (state_q == EXTRACT && cnt_q == CNT_LAST)) begin
                cnt_q <= '0;
            end else if (state_q == EXTRACT) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // NOTE: the captured header and descriptors are not reset; they are only read after an
    // accept has overwritten them, so a reset would add fan-out with no functional effect.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            for (int k = 0; k < CANDI_NUM; k++) begin
                head_q[k] <= i_head_data[k*EXTRACT_WIDTH +: EXTRACT_WIDTH];
            end
            for (int f = 0; f < FIELD_NUM; f++) begin
                desc_q[f] <= i_offset[f*DESC_W +: DESC_W];
            end
        end
    end

    // Lane l handles field cnt*LANE_NUM+l; out-of-range indices are clamped before the array read.
    always_comb begin
        for (int l = 0; l < LANE_NUM; l++) begin
            lane_live[l]  = (int'(cnt_q) * LANE_NUM + l) < FIELD_NUM;
            lane_field[l] = lane_live[l] ? FIELD_IW'(int'(cnt_q) * LANE_NUM + l) : '0;
            lane_desc[l]  = desc_q[lane_field[l]];
            lane_in[l]    = int'(lane_desc[l][OFFSET_WIDTH-1:0]) < CANDI_NUM;
            lane_hit[l]   = lane_live[l] & lane_desc[l][OFFSET_WIDTH] & lane_in[l];
            lane_err[l]   = lane_live[l] & lane_desc[l][OFFSET_WIDTH] & ~lane_in[l];
            lane_unit[l]  = lane_in[l] ? HEAD_IW'(lane_desc[l][OFFSET_WIDTH-1:0]) : '0;
            lane_data[l]  = lane_hit[l] ? head_q[lane_unit[l]] : '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int f = 0; f < FIELD_NUM; f++) begin
                data_q[f] <= '0;
            end
            hit_q <= '0;
            err_q <= '0;
        end else if (accept) begin
            for (int f = 0; f < FIELD_NUM; f++) begin
                data_q[f] <= '0;
            end
            hit_q <= '0;
            err_q <= '0;
        end else if (state_q == EXTRACT) begin
            for (int l = 0; l < LANE_NUM; l++) begin
                if (lane_live[l]) begin
                    data_q[lane_field[l]] <= lane_data[l];
                    hit_q[lane_field[l]]  <= lane_hit[l];
                    err_q[lane_field[l]]  <= lane_err[l];
                end
            end
        end
    end

    always_comb begin
        for (int f = 0; f < FIELD_NUM; f++) begin
            o_field_data[f*EXTRACT_WIDTH +: EXTRACT_WIDTH] = data_q[f];
        end
    end

    assign o_field_hit = hit_q;
    assign o_field_err = err_q;

`ifdef FIELD_EXTRACT_STAT_EN
    function automatic logic [32:0] popcount(input logic [FIELD_NUM-1:0] v);
        logic [32:0] sum;
        sum = '0;
        for (int i = 0; i < FIELD_NUM; i++) begin
            sum = sum + 33'(v[i]);
        end
        return sum;
    endfunction

    logic [32:0] err_sum;
    assign err_sum = {1'b0, o_stat_err_cnt} + popcount(err_q);

    // Both counters saturate at all-ones instead of wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stat_hdr_cnt <= '0;
            o_stat_err_cnt <= '0;
        end else if (deliver) begin
            if (~&o_stat_hdr_cnt) begin
                o_stat_hdr_cnt <= o_stat_hdr_cnt + 32'd1;
            end
            o_stat_err_cnt <= err_sum[32] ? '1 : err_sum[31:0];
        end
    end
`else
    logic unused_deliver;
    assign unused_deliver = deliver;
`endif

endmodule
